// File: rtl/aes_decrypt_iter.sv
`default_nettype none
// ============================================================================
//  Module      : aes_decrypt_iter
//  Description : Iterative AES-128 decryption, one inverse round per clock,
//                with a sequentially built and cached round-key store.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_decrypt_iter #(
    parameter int KEY_CACHE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] cipher_bundle,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [127:0] plaintext,
    output logic [127:0] iv_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXPAND  = 2'd1,
        S_DECRYPT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t       r_state, w_state_nxt;
    logic [3:0]   r_round;
    logic [127:0] r_rk [0:9];
    logic [127:0] r_cached_key, r_iv, r_s, r_plaintext, r_iv_out;
    logic         r_cache_valid, r_busy;
    logic         w_hit;
    logic [127:0] w_rk_cur, w_rk_next, w_round_in, w_round_out;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p, r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] i;
        i = gf_inv(a);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] j);
        case (j)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            default: return 8'h00;
        endcase
    endfunction

    assign w_hit     = (KEY_CACHE != 0) && r_cache_valid && (key == r_cached_key);
    assign w_rk_cur  = r_rk[r_round];
    assign w_rk_next = key_step(r_rk[r_round - 4'd1], rcon(r_round));

    // Round 9 is the first inverse step and undoes the final round, which had no MixColumns
    always_comb begin
        w_round_in = r_s ^ w_rk_cur;
        if (r_round != 4'd9) w_round_in = inv_mix_columns(w_round_in);
        w_round_out = inv_sub_bytes(inv_shift_rows(w_round_in));
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = w_hit ? S_DECRYPT : S_EXPAND;
            S_EXPAND:  if (r_round == 4'd9) w_state_nxt = S_DECRYPT;
            S_DECRYPT: if (r_round == 4'd0) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_round       <= 4'd0;
            r_cache_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_plaintext   <= '0;
            r_iv_out      <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_busy <= 1'b1;
                    if (w_hit) begin
                        r_round <= 4'd9;
                    end else begin
                        r_cache_valid <= 1'b0;
                        r_round       <= 4'd1;
                    end
                end
                // round counter is left at 9 so decryption starts at RK[9]
                S_EXPAND: if (r_round == 4'd9) r_cache_valid <= 1'b1;
                          else                 r_round <= r_round + 4'd1;
                S_DECRYPT: if (r_round == 4'd0) begin
                    r_plaintext <= w_round_out ^ r_rk[0] ^ r_iv;
                    r_iv_out    <= r_iv;
                end else begin
                    r_round <= r_round - 4'd1;
                end
                S_DONE:  r_busy <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_s  <= cipher_bundle[127:0];
                    r_iv <= cipher_bundle[255:128];
                    if (!w_hit) begin
                        r_rk[0]      <= key;
                        r_cached_key <= key;
                    end
                end
                S_EXPAND:  r_rk[r_round] <= w_rk_next;
                S_DECRYPT: r_s <= w_round_out;
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = (r_state == S_DONE);
    assign plaintext = r_plaintext;
    assign iv_out    = r_iv_out;

endmodule
`default_nettype wire

// File: tb/tb_aes_decrypt_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_decrypt_iter
//  Description : Round-trip bench: a forward model builds each bundle, the
//                decryptor must recover the plaintext with the right latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_decrypt_iter;

    logic         clk = 1'b0;
    logic         rst, start_c, start_n;
    logic [255:0] bundle;
    logic [127:0] key;
    logic         busy_c, done_c, busy_n, done_n;
    logic [127:0] pt_c, ivo_c, pt_n, ivo_n;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sb [256];

    typedef struct {
        logic [127:0] p;
        logic [127:0] k;
        logic [127:0] iv;
        int           lat;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;

    aes_decrypt_iter #(.KEY_CACHE(1)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .cipher_bundle(bundle), .key(key),
        .busy(busy_c), .done(done_c), .plaintext(pt_c), .iv_out(ivo_c)
    );

    aes_decrypt_iter #(.KEY_CACHE(0)) dut_n (
        .clk(clk), .rst(rst), .start(start_n), .cipher_bundle(bundle), .key(key),
        .busy(busy_n), .done(done_n), .plaintext(pt_n), .iv_out(ivo_n)
    );

    function automatic logic [7:0] t_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_entry(input logic [7:0] a);
        logic [7:0] inv, o, c;
        inv = 8'h00;
        c   = 8'h63;
        for (int b = 1; b < 256; b++)
            if (t_gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
        for (int i = 0; i < 8; i++)
            o[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
        return o;
    endfunction

    function automatic logic [127:0] t_sub(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sb[s[8*i +: 8]];
        return o;
    endfunction

    function automatic logic [127:0] t_shift(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] t_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = t_gmul(a0, 8'h02) ^ t_gmul(a1, 8'h03) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ t_gmul(a1, 8'h02) ^ t_gmul(a2, 8'h03) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ t_gmul(a2, 8'h02) ^ t_gmul(a3, 8'h03);
            o[103-32*c -: 8] = t_gmul(a0, 8'h03) ^ a1 ^ a2 ^ t_gmul(a3, 8'h02);
        end
        return o;
    endfunction

    // std=1 gives textbook AES-128; std=0 gives the link's encryption path
    function automatic logic [127:0] enc_model(input logic [127:0] p, k, iv, input bit std);
        logic [127:0] rk [0:10];
        logic [127:0] s;
        logic [31:0]  w0, w1, w2, w3, t;
        logic [7:0]   rc;
        rk[0] = k;
        rc    = 8'h01;
        for (int j = 1; j <= 10; j++) begin
            {w0, w1, w2, w3} = rk[j-1];
            t  = {sb[w3[23:16]] ^ rc, sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]};
            w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
            rk[j] = {w0, w1, w2, w3};
            rc = t_gmul(rc, 8'h02);
        end
        s = p ^ rk[0] ^ (std ? 128'h0 : iv);
        for (int r = 1; r <= 10; r++) begin
            s = t_shift(t_sub(s));
            if (r < 10) s = t_mix(s);
            s = s ^ (std ? rk[r] : rk[r-1]);
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called in the cycle where start is to be asserted; returns in the cycle after done
    task automatic run_block(input bit nc, input logic [127:0] p, k, iv, input int exp_lat, input string tag);
        int           lat;
        bit           seen;
        logic [127:0] pt, ivo;
        bundle = {iv, enc_model(p, k, iv, 1'b0)};
        key    = k;
        if (nc) start_n = 1'b1; else start_c = 1'b1;
        tick();
        start_n = 1'b0;
        start_c = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (lat < 40 && !seen) begin
            if (nc ? done_n : done_c) seen = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        pt  = nc ? pt_n : pt_c;
        ivo = nc ? ivo_n : ivo_c;
        chk_int({tag, " latency"}, lat, exp_lat);
        chk({tag, " plaintext"}, pt, p);
        chk({tag, " iv_out"}, ivo, iv);
        tick();
        chk_int({tag, " done width"}, int'(nc ? done_n : done_c), 0);
        chk_int({tag, " busy release"}, int'(nc ? busy_n : busy_c), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] p, k, iv, prev_k, apt, aivo;
        int           ndone, dcyc;

        vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h0, 20};
        vecs[1] = '{128'hffeeddccbbaa99887766554433221100, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h0123456789abcdef0123456789abcdef, 11};
        vecs[2] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'hdeadbeef00000000cafef00d12345678, 20};
        vecs[3] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h000102030405060708090a0b0c0d0e0f, 11};
        vecs[4] = '{128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h000102030405060708090a0b0c0d0e0f,
                    128'hffffffffffffffffffffffffffffffff, 20};

        for (int a = 0; a < 256; a++) sb[a] = sbox_entry(8'(a));
        if (enc_model(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                      128'h0, 1'b1) !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
            $display("FAIL model self-check: reference AES-128 vector not reproduced");
            $fatal(1);
        end

        rst = 1'b1; start_c = 1'b0; start_n = 1'b0; bundle = '0; key = '0;
        tick(); tick(); tick();
        rst = 1'b0;
        chk_int("reset busy", int'(busy_c), 0);
        chk_int("reset done", int'(done_c), 0);
        chk("reset plaintext", pt_c, 128'h0);
        chk("reset iv_out", ivo_c, 128'h0);

        for (int i = 0; i < 5; i++)
            run_block(1'b0, vecs[i].p, vecs[i].k, vecs[i].iv, vecs[i].lat, $sformatf("cache vec%0d", i));
        for (int i = 0; i < 5; i++)
            run_block(1'b1, vecs[i].p, vecs[i].k, vecs[i].iv, 20, $sformatf("nocache vec%0d", i));

        // starts while busy, with inputs toggled, must be ignored
        p = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0; k = vecs[2].k; iv = 128'h55aa55aa55aa55aa55aa55aa55aa55aa;
        bundle = {iv, enc_model(p, k, iv, 1'b0)}; key = k; start_c = 1'b1;
        ndone = 0; dcyc = 0; apt = '0; aivo = '0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            tick();
            start_c = (cyc == 3 || cyc == 15);
            if (cyc == 3 || cyc == 15) begin
                bundle = ~bundle;
                key    = ~key;
            end
            if (done_c) begin
                ndone++;
                dcyc = cyc;
                apt  = pt_c;
                aivo = ivo_c;
            end
        end
        start_c = 1'b0;
        chk_int("busy-start done count", ndone, 1);
        chk_int("busy-start done cycle", dcyc, 20);
        chk("busy-start plaintext", apt, p);
        chk("busy-start iv_out", aivo, iv);

        // reset at cycle 12 of an expansion block
        p = 128'h1234; k = vecs[0].k; iv = 128'h9876;
        bundle = {iv, enc_model(p, k, iv, 1'b0)}; key = k; start_c = 1'b1;
        ndone = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            start_c = 1'b0;
            rst = (cyc == 12);
            if (cyc == 13) begin
                chk_int("mid reset busy", int'(busy_c), 0);
                chk_int("mid reset done", int'(done_c), 0);
                chk("mid reset plaintext", pt_c, 128'h0);
                chk("mid reset iv_out", ivo_c, 128'h0);
            end
            if (done_c) ndone++;
        end
        chk_int("discarded block done count", ndone, 0);

        rst = 1'b1; start_c = 1'b1;
        tick();
        rst = 1'b0; start_c = 1'b0;
        chk_int("start with rst busy", int'(busy_c), 0);
        ndone = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            tick();
            if (done_c) ndone++;
        end
        chk_int("start with rst done count", ndone, 0);
        run_block(1'b0, p, k, iv, 20, "post-reset same key");

        // back-to-back random traffic; every fourth block reuses the previous key
        prev_k = k;
        for (int i = 0; i < 1000; i++) begin
            p  = {$urandom, $urandom, $urandom, $urandom};
            iv = {$urandom, $urandom, $urandom, $urandom};
            if (i % 4 == 3) k = prev_k;
            else            k = {$urandom, $urandom, $urandom, $urandom};
            run_block(1'b0, p, k, iv, (i % 4 == 3) ? 11 : 20, $sformatf("rand%0d", i));
            prev_k = k;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_decrypt_iter.md
Name: aes_decrypt_iter

Overview:
- Iterative AES-128 decryption core; the receive-side counterpart of the encryption path.
- Accepts the 256-bit {iv, ciphertext} bundle that the encryption path emits, plus the cipher key, and recovers the plaintext.
- Processes one inverse round per clock.
- Builds round keys sequentially into a local key store and caches them across blocks that share a key.
- Sits at the receive end of the link, beside the encryption top.

Parameters:
- KEY_CACHE, 1: 1 = skip key expansion when the start-time key equals the cached key; 0 = always expand.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- cipher_bundle  input  256  [255:128] = iv, [127:0] = ciphertext; sampled on accepted start.
- key  input  128  cipher key; sampled on accepted start.
- busy  output  1  high from the cycle after an accepted start through the done cycle.
- done  output  1  one-cycle pulse; plaintext valid.
- plaintext  output  128  recovered block; held until the next done.
- iv_out  output  128  iv of the block presently held in plaintext.

Behaviour:
- Only one clock; reset is synchronous and active-high (clk, rst).

Transform definitions:
- Byte order: byte 0 = bits [127:120], column-major state, standard AES S-box and GF(2^8) arithmetic.
- RK[k] = AES-128 key schedule word-group k, with RK[0] = key.
- The encryption path computes:
  - s = P ^ RK[0] ^ IV
  - rounds r = 1..9: s = MixCol(ShiftRows(SubBytes(s))) ^ RK[r-1]
  - round 10: s = ShiftRows(SubBytes(s)) ^ RK[9]
- This block inverts it exactly:
  - s = InvSubBytes(InvShiftRows(C ^ RK[9]))
  - for r = 9 down to 1: s = InvSubBytes(InvShiftRows(InvMixCol(s ^ RK[r-1])))
  - P = s ^ RK[0] ^ IV
- Only RK[0..9] are needed; RK[10] is never computed.

States: IDLE, EXPAND, DECRYPT, DONE.
- IDLE:
  - On start: latch C, IV and key; busy <= 1.
  - If KEY_CACHE=1, cache_valid=1 and key == cached_key: go to DECRYPT.
  - Otherwise: RK[0] <= key, cached_key <= key, cache_valid <= 0, go to EXPAND.
- EXPAND:
  - 9 cycles; cycle j (j = 1..9) writes RK[j] = schedule step(RK[j-1], Rcon[j]).
  - Rcon[1..9] = 01, 02, 04, 08, 10, 20, 40, 80, 1B.
  - After RK[9] is written: cache_valid <= 1, go to DECRYPT.
- DECRYPT:
  - 10 cycles; round counter runs 9 down to 0.
  - Cycle 1 applies the final-round inverse (no InvMixCol).
  - Cycles 2..10 apply the full inverse rounds.
  - Exit to DONE.
- DONE:
  - 1 cycle: plaintext <= s ^ RK[0] ^ IV, iv_out <= IV, done = 1, busy = 0.
  - Next state IDLE.

Latency, start sampled at cycle 0:
- Cache hit: done at cycle 11.
- Expansion: done at cycle 20.
- Back-to-back: the next start is accepted the cycle after done, i.e. in IDLE.

Boundary conditions:
- start while busy: ignored, no queuing.
- key or cipher_bundle changing while busy: no effect.
- Reset, any cycle:
  - busy = 0, done = 0, plaintext = 0, iv_out = 0.
  - State IDLE; cache_valid = 0; round counter = 0.
  - An in-flight block is discarded and produces no done.
- start coincident with rst: rst wins; start is dropped.
- KEY_CACHE=0: EXPAND always runs; latency is always 20.

Test Plan:
- Round trip: P = 00112233445566778899aabbccddeeff, K = 000102030405060708090a0b0c0d0e0f, IV = 0, bundle from an encryption-path instance -> done at cycle 20, plaintext = P, iv_out = 0.
- Cache hit: second block, same K, P = ffeeddccbbaa99887766554433221100, IV = 0123456789abcdef0123456789abcdef -> done at cycle 11, plaintext = P, iv_out = that IV.
- Key change: third block with K = 2b7e151628aed2a6abf7158809cf4f3c -> re-expands, done at cycle 20, correct P. Repeat with KEY_CACHE=0 -> every block takes 20 cycles.
- start pulsed at cycles 3 and 15 of an active block, with cipher_bundle and key toggled -> exactly one done; result matches the originally latched inputs.
- rst asserted at cycle 12 of an expansion block -> next cycle busy = 0, done = 0, plaintext = 0. A following same-key start takes 20 cycles (cache invalidated).
- 1000 random (P, K, IV) round trips with consecutive starts issued the cycle after done -> all match; done is never wider than 1 cycle.
